muldiv_unit: RTL

- Iterative RV64M multiply/divide unit in the execute stage, beside the integer ALU.
- Takes the same rs1/rs2 operands and funct3 the ALU receives.
- Produces a 64-bit result that the execute-stage result mux selects in place of the ALU result when the instruction is an M-extension op (funct7 = 0000001).
- Multi-cycle with a start/busy/done handshake; the control unit stalls the pipeline while busy.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Handshake/operand bundle between the execute stage and the multiply/divide unit.
//   start, kill, s1, s2, funct3 : requester -> unit
//   busy, done, res             : unit -> requester
interface muldiv_if #(
  parameter int SIZE = 64
);
  logic            start;
  logic            kill;
  logic [SIZE-1:0] s1;
  logic [SIZE-1:0] s2;
  logic [2:0]      funct3;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] res;

  modport master (
    output start, kill, s1, s2, funct3,
    input  busy, done, res
  );

  modport slave (
    input  start, kill, s1, s2, funct3,
    output busy, done, res
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit, one radix-2 step per clock.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus.start    request, sampled only in IDLE
//   bus.kill     flush, aborts any operation in progress
//   bus.s1/s2    operands rs1/rs2
//   bus.funct3   000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   bus.busy     high while iterating
//   bus.done     one-cycle result-valid pulse
//   bus.res      result register, held until the next completion
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands latched when it is accepted
// BUSY  | one shift-add / restoring-divide step per clock, SIZE steps
// DONE  | res just written; single cycle, then back to IDLE
module muldiv_unit #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_if.slave     bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  localparam int            CW       = $clog2(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);
  localparam logic [SIZE-1:0] MIN_NEG = {1'b1, {(SIZE-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*SIZE-1:0] acc_q, acc_d;     // product, or {remainder, quotient}
  logic [SIZE-1:0]   opd_q, opd_d;     // multiplicand / divisor magnitude
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;     // negate product / quotient at the end
  logic              negr_q, negr_d;   // negate remainder at the end
  logic [SIZE-1:0]   res_q, res_d;

  assign bus.busy = (state_q == ST_BUSY);
  assign bus.done = (state_q == ST_DONE);
  assign bus.res  = res_q;

  // Operand sign interpretation at start
  logic            s1_signed, s2_signed, s1_neg, s2_neg;
  logic [SIZE-1:0] s1_mag, s2_mag;
  logic            is_div, div_zero, div_ovf;

  always_comb begin
    s1_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    s2_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                (bus.funct3 == 3'b110);
    s1_neg    = s1_signed & bus.s1[SIZE-1];
    s2_neg    = s2_signed & bus.s2[SIZE-1];
    s1_mag    = s1_neg ? (~bus.s1 + 1'b1) : bus.s1;
    s2_mag    = s2_neg ? (~bus.s2 + 1'b1) : bus.s2;
    is_div    = bus.funct3[2];
    div_zero  = is_div && (bus.s2 == '0);
    // signed overflow: most negative value divided by -1
    div_ovf   = is_div && !bus.funct3[0] && (bus.s1 == MIN_NEG) && (bus.s2 == '1);
  end

  // One iteration step
  logic [SIZE:0]     mul_sum, div_top, div_diff;
  logic [2*SIZE-1:0] mul_next, div_next, step_next, prod;
  logic [SIZE-1:0]   quo, rem, final_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next = {mul_sum, acc_q[SIZE-1:1]};

    // Remainder before the shift is below the divisor, so the shifted
    // partial remainder fits in SIZE+1 bits and the difference in SIZE.
    div_top  = acc_q[2*SIZE-1:SIZE-1];
    div_diff = div_top - {1'b0, opd_q};
    div_next = div_diff[SIZE] ? {acc_q[2*SIZE-2:0], 1'b0}
                              : {div_diff[SIZE-1:0], acc_q[SIZE-2:0], 1'b1};

    step_next = f3_q[2] ? div_next : mul_next;

    prod = neg_q ? (~step_next + 1'b1) : step_next;
    quo  = step_next[SIZE-1:0];
    rem  = step_next[2*SIZE-1:SIZE];

    case (f3_q)
      3'b000:                 final_res = prod[SIZE-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*SIZE-1:SIZE];
      3'b100, 3'b101:         final_res = neg_q  ? (~quo + 1'b1) : quo;
      default:                final_res = negr_q ? (~rem + 1'b1) : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          f3_d = bus.funct3;
          if (div_zero) begin
            res_d   = bus.funct3[1] ? bus.s1 : '1;
            state_d = ST_DONE;
          end else if (div_ovf) begin
            res_d   = bus.funct3[1] ? '0 : bus.s1;
            state_d = ST_DONE;
          end else begin
            acc_d   = {{SIZE{1'b0}}, s1_mag};
            opd_d   = s2_mag;
            neg_d   = s1_neg ^ s2_neg;
            negr_d  = s1_neg;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        acc_d = step_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d   = final_res;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.kill) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

endmodule
